// File: rtl/dm_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter_pkg
//
// Shared definitions for the data-memory port arbiter and its neighbours.
//   DM_DATA_W / DM_ADDR_W : geometry of the 512x16 single-port data memory,
//                           also used by the core-side address/input muxes.
//   arb_state_e           : arbiter FSM state encoding.
//   ARB_CNT_W             : width of the starvation and burst counters
//                           (their limits are 1..255).
//   sat_cnt8()            : converts an integer limit to counter width.
// -----------------------------------------------------------------------------
package dm_port_arbiter_pkg;

    localparam int DM_DATA_W = 16;
    localparam int DM_ADDR_W = 9;
    localparam int ARB_CNT_W = 8;

    typedef enum logic [1:0] {
        S_CORE_PRI   = 2'd0,  // core has priority, host waits
        S_HOST_FORCE = 2'd1,  // host starved long enough, host owns the port
        S_HOST_BURST = 2'd2   // host holds the port under host_lock
    } arb_state_e;

    // Limits outside 1..255 are clamped so the counters never wrap silently.
    function automatic logic [ARB_CNT_W-1:0] sat_cnt8(input int limit);
        if (limit < 1) begin
            return ARB_CNT_W'(1);
        end else if (limit > 255) begin
            return ARB_CNT_W'(255);
        end else begin
            return ARB_CNT_W'(limit);
        end
    endfunction

endpackage : dm_port_arbiter_pkg

// File: rtl/dm_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter_if
//
// Bundle of all bus signals around the data-memory arbiter.
//   Core side : core_req, core_we, core_addr, core_wdata -> core_rdata, core_stall
//   Host side : host_req, host_we, host_lock, host_addr, host_wdata
//               -> host_gnt, host_rvalid, host_rdata
//   Memory    : dm_w, dm_addr, dm_in -> dm_out (combinational read data)
//
// Modports:
//   slave  : the arbiter itself.
//   master : the surrounding requesters and data memory.
// -----------------------------------------------------------------------------
import dm_port_arbiter_pkg::*;

interface dm_port_arbiter_if #(
    parameter int DATA_W = DM_DATA_W,
    parameter int ADDR_W = DM_ADDR_W
);

    // Core load/store/stack path
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;

    // Host/debug port
    logic              host_req;
    logic              host_we;
    logic              host_lock;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    // Data memory
    logic              dm_w;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_in;
    logic [DATA_W-1:0] dm_out;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_stall,
        input  host_req, host_we, host_lock, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        output dm_w, dm_addr, dm_in,
        input  dm_out
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_stall,
        output host_req, host_we, host_lock, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  dm_w, dm_addr, dm_in,
        output dm_out
    );

endinterface : dm_port_arbiter_if

// File: rtl/dm_arb_fsm.sv
// -----------------------------------------------------------------------------
// dm_arb_fsm
//
// Grant decision for the shared data-memory port. Holds the arbitration
// state, the host starvation counter and the host burst counter.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   core_req   in   core wants the port this cycle
//   host_req   in   host wants the port this cycle
//   host_lock  in   host asks to keep the port for a burst
//   grant_host out  host owns the port this cycle (combinational)
// -----------------------------------------------------------------------------
import dm_port_arbiter_pkg::*;

module dm_arb_fsm #(
    parameter int STARVE_MAX = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic core_req,
    input  logic host_req,
    input  logic host_lock,
    output logic grant_host
);

    localparam logic [ARB_CNT_W-1:0] STARVE_LIM = sat_cnt8(STARVE_MAX);
    localparam logic [ARB_CNT_W-1:0] BURST_LIM  = sat_cnt8(BURST_MAX);

    arb_state_e           state_q,  state_d;
    logic [ARB_CNT_W-1:0] wait_q,   wait_d;
    logic [ARB_CNT_W-1:0] burst_q,  burst_d;
    logic [ARB_CNT_W-1:0] wait_inc;

    assign wait_inc = wait_q + ARB_CNT_W'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_CORE_PRI;
            wait_q  <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            burst_q <= burst_d;
        end
    end

    // NOTE: every output of this block is assigned a default before the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        burst_d    = burst_q;
        grant_host = 1'b0;

        unique case (state_q)
            S_CORE_PRI: begin
                grant_host = host_req & ~core_req;
                if (host_req && core_req) begin
                    // Host denied: count towards a forced grant.
                    wait_d = wait_inc;
                    if (wait_inc == STARVE_LIM) begin
                        state_d = S_HOST_FORCE;
                    end
                end else begin
                    wait_d = '0;
                    if (grant_host && host_lock) begin
                        state_d = S_HOST_BURST;
                        burst_d = ARB_CNT_W'(1);
                    end
                end
            end

            S_HOST_FORCE: begin
                grant_host = host_req;
                wait_d     = '0;
                if (grant_host && host_lock) begin
                    state_d = S_HOST_BURST;
                    burst_d = ARB_CNT_W'(1);
                end else begin
                    // Either granted once or the host gave up; the core gets
                    // at least one priority cycle next.
                    state_d = S_CORE_PRI;
                end
            end

            S_HOST_BURST: begin
                grant_host = host_req & host_lock & (burst_q < BURST_LIM);
                if (grant_host) begin
                    burst_d = burst_q + ARB_CNT_W'(1);
                end else begin
                    // Burst over: the core owns the port in this same cycle.
                    state_d = S_CORE_PRI;
                    burst_d = '0;
                    wait_d  = '0;
                end
            end

            default: begin
                state_d = S_CORE_PRI;
                wait_d  = '0;
                burst_d = '0;
            end
        endcase
    end

endmodule : dm_arb_fsm

// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
//
// Shares the single-port data memory between the core load/store/stack path
// and the host/debug port. The core has default priority; a starved host is
// eventually forced through, and the host may lock the port for a short burst.
// The core only ever sees contention as core_stall.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous, active-low reset
//   bus   slave modport of dm_port_arbiter_if (core, host and memory signals)
//
// Timing:
//   host_gnt, core_stall, dm_* and core_rdata are combinational.
//   A host read granted in cycle N returns host_rvalid/host_rdata in cycle N+1.
// -----------------------------------------------------------------------------
import dm_port_arbiter_pkg::*;

module dm_port_arbiter #(
    parameter int DATA_W     = DM_DATA_W,
    parameter int ADDR_W     = DM_ADDR_W,
    parameter int STARVE_MAX = 8,
    parameter int BURST_MAX  = 4
) (
    input logic               clk,
    input logic               rst,
    dm_port_arbiter_if.slave  bus
);

    logic              grant_host;
    logic              host_rvalid_q;
    logic [DATA_W-1:0] host_rdata_q;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    dm_arb_fsm #(
        .STARVE_MAX (STARVE_MAX),
        .BURST_MAX  (BURST_MAX)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .core_req   (bus.core_req),
        .host_req   (bus.host_req),
        .host_lock  (bus.host_lock),
        .grant_host (grant_host)
    );

    // Single owner per cycle. A core cycle without core_req never writes.
    always_comb begin
        if (grant_host) begin
            sel_addr  = bus.host_addr;
            sel_wdata = bus.host_wdata;
            sel_we    = bus.host_we;
        end else begin
            sel_addr  = bus.core_addr;
            sel_wdata = bus.core_wdata;
            sel_we    = bus.core_we & bus.core_req;
        end
    end

    assign bus.dm_addr    = sel_addr;
    assign bus.dm_in      = sel_wdata;
    // Reset gates the write strobe directly so no stray write can occur while
    // the arbiter state is being cleared.
    assign bus.dm_w       = rst & sel_we;

    assign bus.core_rdata = bus.dm_out;
    assign bus.core_stall = bus.core_req & grant_host;
    assign bus.host_gnt   = grant_host;

    // Host read return: capture memory output at the edge closing the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            host_rvalid_q <= grant_host & ~bus.host_we;
            if (grant_host && !bus.host_we) begin
                host_rdata_q <= bus.dm_out;
            end
        end
    end

    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_rdata  = host_rdata_q;

endmodule : dm_port_arbiter
